// File: rtl/sdram_pkg.sv
// Shared SDRAM command/state encodings and burst constants for the responder and its controller.
package sdram_pkg;

    localparam int unsigned BURST_LEN = 8;
    localparam int unsigned ADDR_W    = 12;

    typedef enum logic [2:0] {
        CMD_REFRESH = 3'b001,
        CMD_ACTIVE  = 3'b011,
        CMD_WRITE   = 3'b100,
        CMD_READ    = 3'b101,
        CMD_NOP     = 3'b111
    } sdram_cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        ROW_OPEN,
        RD_LAT,
        RD_BURST,
        WR_WAIT,
        WR_BURST,
        REFRESH
    } sdram_state_e;

    // Unlisted strobe combinations behave as NOP.
    function automatic sdram_cmd_e decode_cmd(input logic ras_n, input logic cas_n, input logic we_n);
        case ({ras_n, cas_n, we_n})
            3'b011:  return CMD_ACTIVE;
            3'b101:  return CMD_READ;
            3'b100:  return CMD_WRITE;
            3'b001:  return CMD_REFRESH;
            default: return CMD_NOP;
        endcase
    endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// 1R1W synchronous 32-bit word store backing the SDRAM responder; contents survive reset.
module sdram_resp_mem #(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sdram_responder.sv
// Behavioural SDRAM device model: nibble-wide read/write bursts of one 32-bit word, refresh counting.
// Optional protocol checking of ignored commands is enabled with `define SDRAM_RESP_ERRCHK_EN.
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int unsigned CL     = 2,
    parameter int unsigned WR_DLY = 3,
    parameter int unsigned MEM_AW = 8,
    parameter int unsigned TRFC   = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        RAS_N,
    input  logic        CAS_N,
    input  logic        WE_N,
    input  logic [31:0] SA,
    input  logic [3:0]  DQ_I,
    output logic [3:0]  DQ_O,
    output logic        DQ_OE,
    output logic        R_DATAEND,
    output logic [15:0] REF_CNT,
    output logic        ERR
);

    localparam int unsigned HALF_AW = MEM_AW / 2;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned BEAT_W  = 4;

    sdram_state_e        state_q, state_d;
    sdram_cmd_e          cmd_c;
    logic [ADDR_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]   col_q, col_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [31:0]         word_q, word_d;
    logic [15:0]         ref_cnt_q, ref_cnt_d;
    logic [3:0]          dq_o_q, dq_o_d;
    logic                dq_oe_q, dq_oe_d;
    logic                r_dataend_q, r_dataend_d;

    logic                mem_re_c;
    logic                mem_we_c;
    logic [MEM_AW-1:0]   mem_raddr_c;
    logic [MEM_AW-1:0]   mem_waddr_c;
    logic [31:0]         mem_rdata;
    logic [2:0]          nib_next_c;
    logic                unused_c;

    assign cmd_c       = decode_cmd(RAS_N, CAS_N, WE_N);
    assign mem_raddr_c = MEM_AW'({row_q[HALF_AW-1:0], SA[HALF_AW-1:0]});
    assign mem_waddr_c = MEM_AW'({row_q[HALF_AW-1:0], col_q[HALF_AW-1:0]});
    assign nib_next_c  = 3'(beat_q[2:0] + 3'd1);
    assign unused_c    = ^{SA[31:ADDR_W], row_q[ADDR_W-1:HALF_AW], col_q[ADDR_W-1:HALF_AW]};

    sdram_resp_mem #(.AW(MEM_AW)) u_mem (
        .clk   (CLK),
        .re    (mem_re_c),
        .raddr (mem_raddr_c),
        .rdata (mem_rdata),
        .we    (mem_we_c),
        .waddr (mem_waddr_c),
        .wdata (word_q)
    );

    always_ff @(posedge CLK or posedge RESET_N) begin
        if (RESET_N) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            cnt_q       <= '0;
            beat_q      <= '0;
            word_q      <= '0;
            ref_cnt_q   <= '0;
            dq_o_q      <= '0;
            dq_oe_q     <= 1'b0;
            r_dataend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            beat_q      <= beat_d;
            word_q      <= word_d;
            ref_cnt_q   <= ref_cnt_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
            r_dataend_q <= r_dataend_d;
        end
    end

    // Command acceptance and burst sequencing; the memory is read on the READ edge itself
    // so the word is already stable when the latency counter expires.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        beat_d      = beat_q;
        word_d      = word_q;
        ref_cnt_d   = ref_cnt_q;
        dq_o_d      = '0;
        dq_oe_d     = 1'b0;
        r_dataend_d = 1'b0;
        mem_re_c    = 1'b0;
        mem_we_c    = 1'b0;

        case (state_q)
            IDLE, ROW_OPEN: begin
                case (cmd_c)
                    CMD_ACTIVE: begin
                        row_d   = SA[ADDR_W-1:0];
                        state_d = ROW_OPEN;
                    end
                    CMD_REFRESH: begin
                        ref_cnt_d = ref_cnt_q + 16'd1;
                        row_d     = '0;
                        cnt_d     = CNT_W'(TRFC - 1);
                        state_d   = REFRESH;
                    end
                    CMD_READ: begin
                        if (state_q == ROW_OPEN) begin
                            col_d    = SA[ADDR_W-1:0];
                            mem_re_c = 1'b1;
                            cnt_d    = CNT_W'(CL - 1);
                            state_d  = RD_LAT;
                        end
                    end
                    CMD_WRITE: begin
                        if (state_q == ROW_OPEN) begin
                            col_d   = SA[ADDR_W-1:0];
                            word_d  = '0;
                            cnt_d   = CNT_W'(WR_DLY - 1);
                            state_d = WR_WAIT;
                        end
                    end
                    default: ;
                endcase
            end
            RD_LAT: begin
                if (cnt_q == '0) begin
                    dq_oe_d = 1'b1;
                    dq_o_d  = mem_rdata[3:0];
                    beat_d  = '0;
                    state_d = RD_BURST;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RD_BURST: begin
                // beat_q is the nibble currently on DQ_O
                if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
                    state_d = ROW_OPEN;
                end else begin
                    dq_oe_d     = 1'b1;
                    dq_o_d      = mem_rdata[{nib_next_c, 2'b00} +: 4];
                    r_dataend_d = (beat_q == BEAT_W'(BURST_LEN - 2));
                    beat_d      = beat_q + BEAT_W'(1);
                end
            end
            WR_WAIT: begin
                if (cnt_q == '0) begin
                    word_d[3:0] = DQ_I;
                    beat_d      = BEAT_W'(1);
                    state_d     = WR_BURST;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR_BURST: begin
                if (beat_q == BEAT_W'(BURST_LEN)) begin
                    mem_we_c = 1'b1;
                    state_d  = ROW_OPEN;
                end else begin
                    word_d[{beat_q[2:0], 2'b00} +: 4] = DQ_I;
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            REFRESH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SDRAM_RESP_ERRCHK_EN
    logic ignored_c;
    logic err_q;

    // A command is ignored when busy, or when READ/WRITE arrives with no open row.
    always_comb begin
        ignored_c = 1'b0;
        if (cmd_c != CMD_NOP) begin
            case (state_q)
                IDLE:     ignored_c = (cmd_c == CMD_READ) || (cmd_c == CMD_WRITE);
                ROW_OPEN: ignored_c = 1'b0;
                default:  ignored_c = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET_N) begin
        if (RESET_N) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | ignored_c;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    assign DQ_O      = dq_o_q;
    assign DQ_OE     = dq_oe_q;
    assign R_DATAEND = r_dataend_q;
    assign REF_CNT   = ref_cnt_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed self-checking bench for sdram_responder; expected ERR follows SDRAM_RESP_ERRCHK_EN.
module tb_sdram_responder;

    localparam int unsigned CL     = 2;
    localparam int unsigned WR_DLY = 3;
    localparam int unsigned MEM_AW = 8;
    localparam int unsigned TRFC   = 4;

`ifdef SDRAM_RESP_ERRCHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    localparam logic [2:0] C_NOP = 3'b111;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_REF = 3'b001;

    localparam logic [31:0] W1 = 32'h89AB_CDEF;
    localparam logic [31:0] W2 = 32'h1234_5678;
    localparam logic [31:0] W3 = 32'hCAFE_F00D;

    logic        CLK;
    logic        RESET_N;
    logic        RAS_N, CAS_N, WE_N;
    logic [31:0] SA;
    logic [3:0]  DQ_I;
    logic [3:0]  DQ_O;
    logic        DQ_OE;
    logic        R_DATAEND;
    logic [15:0] REF_CNT;
    logic        ERR;

    int checks = 0;
    int errors = 0;

    sdram_responder #(.CL(CL), .WR_DLY(WR_DLY), .MEM_AW(MEM_AW), .TRFC(TRFC)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .RAS_N     (RAS_N),
        .CAS_N     (CAS_N),
        .WE_N      (WE_N),
        .SA        (SA),
        .DQ_I      (DQ_I),
        .DQ_O      (DQ_O),
        .DQ_OE     (DQ_OE),
        .R_DATAEND (R_DATAEND),
        .REF_CNT   (REF_CNT),
        .ERR       (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one command for a single edge, return at the following negedge.
    task automatic issue(input logic [2:0] c, input logic [31:0] a);
        {RAS_N, CAS_N, WE_N} = c;
        SA = a;
        @(negedge CLK);
        {RAS_N, CAS_N, WE_N} = C_NOP;
    endtask

    task automatic pulse_reset();
        RESET_N = 1'b1;
        @(negedge CLK);
        RESET_N = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] w);
        issue(C_WR, a);
        repeat (WR_DLY - 1) @(negedge CLK);
        for (int k = 0; k < 8; k++) begin
            DQ_I = w[4*k +: 4];
            @(negedge CLK);
        end
        DQ_I = 4'h0;
        @(negedge CLK);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] w, input bit inject);
        issue(C_RD, a);
        chk({tag, "_oe_cmd"}, 32'(DQ_OE), 32'h0);
        repeat (CL - 1) begin
            @(negedge CLK);
            chk({tag, "_oe_lat"}, 32'(DQ_OE), 32'h0);
        end
        for (int k = 0; k < 8; k++) begin
            if (inject && k == 2) begin
                {RAS_N, CAS_N, WE_N} = C_ACT;
                SA = 32'h7;
            end
            @(negedge CLK);
            {RAS_N, CAS_N, WE_N} = C_NOP;
            chk($sformatf("%s_oe%0d", tag, k), 32'(DQ_OE), 32'h1);
            chk($sformatf("%s_dq%0d", tag, k), 32'(DQ_O), 32'(w[4*k +: 4]));
            chk($sformatf("%s_end%0d", tag, k), 32'(R_DATAEND), (k == 7) ? 32'h1 : 32'h0);
        end
        @(negedge CLK);
        chk({tag, "_oe_done"}, 32'(DQ_OE), 32'h0);
        chk({tag, "_end_done"}, 32'(R_DATAEND), 32'h0);
    endtask

    initial begin
        RESET_N = 1'b1;
        {RAS_N, CAS_N, WE_N} = C_NOP;
        SA   = 32'h0;
        DQ_I = 4'h0;

        // Reset values
        @(negedge CLK);
        chk("rst_oe", 32'(DQ_OE), 32'h0);
        chk("rst_dq", 32'(DQ_O), 32'h0);
        chk("rst_end", 32'(R_DATAEND), 32'h0);
        chk("rst_ref", 32'(REF_CNT), 32'h0);
        chk("rst_err", 32'(ERR), 32'h0);
        RESET_N = 1'b0;
        @(negedge CLK);

        // Basic write then read, row 5 col 3
        issue(C_ACT, 32'h005);
        do_write(32'h003, W1);
        do_read("rd1", 32'h003, W1, 1'b0);
        chk("rd1_err", 32'(ERR), 32'h0);

        // ACTIVE during burst is ignored; row stays 5
        do_read("rd_inj", 32'h003, W1, 1'b1);
        chk("inj_err", 32'(ERR), 32'(ERR_EXP));
        do_read("rd_inj2", 32'h003, W1, 1'b0);

        // Async reset at the 4th read nibble
        pulse_reset();
        issue(C_ACT, 32'h005);
        issue(C_RD, 32'h003);
        repeat (CL - 1) @(negedge CLK);
        repeat (4) @(negedge CLK);
        chk("mid_dq3", 32'(DQ_O), 32'hC);
        chk("mid_oe3", 32'(DQ_OE), 32'h1);
        #1 RESET_N = 1'b1;
        #1;
        chk("mid_rst_oe", 32'(DQ_OE), 32'h0);
        chk("mid_rst_end", 32'(R_DATAEND), 32'h0);
        chk("mid_rst_dq", 32'(DQ_O), 32'h0);
        @(negedge CLK);
        chk("mid_rst_end2", 32'(R_DATAEND), 32'h0);
        RESET_N = 1'b0;
        @(negedge CLK);
        chk("mid_rst_err", 32'(ERR), 32'h0);
        issue(C_ACT, 32'h005);
        do_read("rd_after_rst", 32'h003, W1, 1'b0);

        // Write burst aborted by reset leaves memory untouched
        issue(C_WR, 32'h003);
        repeat (WR_DLY - 1) @(negedge CLK);
        for (int k = 0; k < 5; k++) begin
            DQ_I = 4'h0;
            @(negedge CLK);
        end
        pulse_reset();
        issue(C_ACT, 32'h005);
        do_read("rd_wr_abort", 32'h003, W1, 1'b0);

        // READ with no open row is ignored
        pulse_reset();
        issue(C_RD, 32'h003);
        for (int c = 0; c < int'(CL) + 9; c++) begin
            chk($sformatf("idle_rd_oe%0d", c), 32'(DQ_OE), 32'h0);
            @(negedge CLK);
        end
        chk("idle_rd_err", 32'(ERR), 32'(ERR_EXP));

        // Refresh counting and busy window
        pulse_reset();
        chk("ref_rst_err", 32'(ERR), 32'h0);
        chk("ref_rst_cnt", 32'(REF_CNT), 32'h0);
        issue(C_REF, 32'h0);
        chk("ref_cnt1", 32'(REF_CNT), 32'h1);
        issue(C_REF, 32'h0);
        chk("ref_busy", 32'(REF_CNT), 32'h1);
        chk("ref_busy_err", 32'(ERR), 32'(ERR_EXP));
        repeat (TRFC - 1) @(negedge CLK);
        issue(C_REF, 32'h0);
        chk("ref_cnt2", 32'(REF_CNT), 32'h2);
        repeat (TRFC) @(negedge CLK);
        issue(C_REF, 32'h0);
        chk("ref_cnt3", 32'(REF_CNT), 32'h3);
        repeat (TRFC) @(negedge CLK);

        // Two columns of row 0x00F are independent words
        issue(C_ACT, 32'h00F);
        do_write(32'h000, W2);
        do_write(32'h0FF, W3);
        do_read("rd_c00", 32'h000, W2, 1'b0);
        do_read("rd_cff", 32'h0FF, W3, 1'b0);
        chk("final_ref", 32'(REF_CNT), 32'h3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
